sr_latch_checker: RTL and testbench
===================================

# sr_latch_checker

Clocked checker for the SR latch family: samples the EN/S/R commands applied to a latch under test together with its Q/Qbar outputs, maintains a cycle-accurate reference model, and reports mismatches and invalid-command events. It is the receiving/checking end of the latch stimulus interface. It sits beside any SR latch instance, both in simulation and on-chip, and exposes saturating counters and a state code for debug.

## Interface
Parameters:
- SETTLE, 2: cycles after any change of {EN,S,R} before Q/Qbar are compared (1..15)
- CNT_W, 8: width of err_count and chk_count

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- EN  in  1  observed latch enable (synchronous to clk)
- S  in  1  observed set
- R  in  1  observed reset
- Q  in  1  observed latch output
- Qbar  in  1  observed complementary output
- clear  in  1  synchronous clear of counters and sticky flag
- exp_q  out  1  reference-model Q (valid when exp_known=1)
- exp_known  out  1  model state is defined
- mismatch  out  1  one-cycle pulse: compare failed
- invalid_seen  out  1  sticky: EN=1 with S=R=1 observed
- err_count  out  CNT_W  saturating mismatch count
- chk_count  out  CNT_W  saturating compare count
- state  out  2  FSM state code

## Operation
- Reference model, evaluated every cycle on sampled inputs: EN=0 hold; EN=1: S=1,R=0 -> 1 known; S=0,R=1 -> 0 known; S=R=0 hold; S=R=1 -> unknown (exp_known=0).
- FSM states: UNKNOWN(0), SETTLE(1), CHECK(2), INVALID(3).
- UNKNOWN: no compares. Leaves to SETTLE when the model becomes known.
- SETTLE: down-counter loaded with SETTLE-1 on entry or on any change of {EN,S,R}. Goes to CHECK when the counter reaches 0 with inputs stable.
- CHECK: compares every cycle. Pass requires Q==exp_q and Qbar==~exp_q. Each compare increments chk_count. A fail pulses mismatch and increments err_count. Any input change returns to SETTLE.
- INVALID: entered from any state when EN=1 and S=R=1. Sets invalid_seen; no compares. Exit goes to UNKNOWN, or to SETTLE if the next command is a valid EN=1 set/reset.
- EN=0 with any S/R while the model is unknown: stays UNKNOWN; the latch is not enabled.
- Counters saturate at 2^CNT_W-1 and do not wrap.

## Timing
- Reset values: exp_q=0, exp_known=0, mismatch=0, invalid_seen=0, err_count=0, chk_count=0, state=UNKNOWN, settle counter=0.
- Reset asserted mid-operation clears everything immediately, regardless of clk.
- The model updates at the clk edge that samples the command; exp_q and exp_known are visible the following cycle.
- First compare occurs SETTLE cycles after the last input change.
- mismatch is registered: high for exactly one cycle, the cycle after the failing sample. err_count reflects the failure in the same cycle mismatch is high.
- An input change on a compare cycle takes priority: no compare is made and the FSM goes to SETTLE.
- clear coincident with mismatch: counters go to 0 and invalid_seen goes to 0; the mismatch pulse still fires.
- clear does not change the FSM state or the model.

## Structure
- Package sr_chk_pkg: state enum typedef (UNKNOWN/SETTLE/CHECK/INVALID with fixed 2-bit encodings) and the SETTLE maximum constant.
- Sub-module sr_ref_model: registered latch model. Inputs EN/S/R; outputs exp_q/exp_known. Instantiated once.
- Top level holds the FSM, settle counter, previous-input register, comparator and counters.

## Test plan
- Reset, then EN=1,S=1,R=0 with a correct latch -> UNKNOWN->SETTLE->CHECK; after SETTLE=2 cycles chk_count increments each cycle; err_count=0.
- Set, then S=R=0 (hold), then R=1 (reset), then hold, all correct -> exp_q follows 1,1,0,0; no mismatch; state revisits SETTLE at each change.
- Force Q=0,Qbar=1 while the model is 1 in CHECK -> mismatch pulses for one cycle; err_count=1. Repeat for 300 cycles with CNT_W=8 -> err_count stays at 255.
- EN=1,S=R=1 -> state=INVALID, invalid_seen=1, no compares. Then EN=0,S=1 -> stays UNKNOWN. Then EN=1,S=1 -> SETTLE, then CHECK with exp_q=1.
- Toggle S on the exact cycle a compare would occur with a wrong Q -> no mismatch; state=SETTLE.
- Assert rst mid-CHECK between clk edges -> all outputs return to reset values immediately. Assert clear together with a failing compare -> counters read 0 and mismatch still pulses.

Source files
------------

// File: rtl/sr_chk_pkg.sv
// -----------------------------------------------------------------------------
// sr_chk_pkg
//
// Shared types and constants for the SR latch checker.
//   chk_state_t  : checker FSM state, with fixed 2-bit codes that are exported
//                  on the checker's state port for debug.
//   sr_cmd_t     : one sampled latch command {en, s, r}.
//   SETTLE_MAX   : largest settle time the checker's counter can hold.
//   is_invalid() : EN=1 with S=R=1, the forbidden SR latch command.
//   is_drive()   : EN=1 with exactly one of S/R, a command that defines Q.
// -----------------------------------------------------------------------------
package sr_chk_pkg;

    typedef enum logic [1:0] {
        ST_UNKNOWN = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CHECK   = 2'd2,
        ST_INVALID = 2'd3
    } chk_state_t;

    localparam int SETTLE_MAX   = 15;
    localparam int SETTLE_CNT_W = 4;

    typedef struct packed {
        logic en;
        logic s;
        logic r;
    } sr_cmd_t;

    function automatic logic is_invalid(input sr_cmd_t c);
        return c.en & c.s & c.r;
    endfunction

    function automatic logic is_drive(input sr_cmd_t c);
        return c.en & (c.s ^ c.r);
    endfunction

endpackage

// File: rtl/sr_ref_model.sv
// -----------------------------------------------------------------------------
// sr_ref_model
//
// Registered behavioural model of a gated SR latch, evaluated once per clock
// on the sampled command. The result is visible the cycle after the command
// is sampled.
//
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   EN, S, R   : sampled latch command
//   exp_q      : modelled Q (meaningful only while exp_known=1)
//   exp_known  : modelled state is defined
// -----------------------------------------------------------------------------
module sr_ref_model
    import sr_chk_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic EN,
    input  logic S,
    input  logic R,
    output logic exp_q,
    output logic exp_known
);

    // Stage p0 -> p1: latch state update on the sampled command
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q     <= 1'b0;
            exp_known <= 1'b0;
        end else if (EN) begin
            if (S && R) begin
                // Forbidden command: the real latch output is undefined.
                // exp_q keeps its old value but is flagged as meaningless.
                exp_known <= 1'b0;
            end else if (S) begin
                exp_q     <= 1'b1;
                exp_known <= 1'b1;
            end else if (R) begin
                exp_q     <= 1'b0;
                exp_known <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sr_latch_checker.sv
// -----------------------------------------------------------------------------
// sr_latch_checker
//
// Clocked checker placed beside an SR latch under test. It samples the latch
// command {EN,S,R} and the latch outputs Q/Qbar, keeps a reference model of
// the latch, waits SETTLE cycles after every command change and then compares
// the latch outputs against the model every cycle.
//
// Parameters:
//   SETTLE : cycles from the last command change to the first compare (1..15)
//   CNT_W  : width of err_count / chk_count
//
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   EN, S, R      : observed latch command
//   Q, Qbar       : observed latch outputs
//   clear         : synchronous clear of counters and invalid_seen
//   exp_q         : reference-model Q
//   exp_known     : reference model is defined
//   mismatch      : one-cycle pulse, the cycle after a failing compare
//   invalid_seen  : sticky, EN=1 with S=R=1 was observed
//   err_count     : saturating count of failed compares
//   chk_count     : saturating count of compares
//   state         : FSM state code (UNKNOWN/SETTLE/CHECK/INVALID)
// -----------------------------------------------------------------------------
module sr_latch_checker
    import sr_chk_pkg::*;
#(
    parameter int SETTLE = 2,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             EN,
    input  logic             S,
    input  logic             R,
    input  logic             Q,
    input  logic             Qbar,
    input  logic             clear,
    output logic             exp_q,
    output logic             exp_known,
    output logic             mismatch,
    output logic             invalid_seen,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] chk_count,
    output logic [1:0]       state
);

    // Out-of-range SETTLE values are clamped to what the counter can hold.
    localparam int SETTLE_EFF = (SETTLE < 1)          ? 1 :
                                (SETTLE > SETTLE_MAX) ? SETTLE_MAX : SETTLE;

    localparam logic [SETTLE_CNT_W-1:0] SETTLE_LOAD = SETTLE_CNT_W'(SETTLE_EFF - 1);

    // With a one-cycle settle time the counter is already at zero on entry,
    // so the checker goes straight to CHECK and compares on the next sample.
    localparam chk_state_t SETTLE_ENTRY = (SETTLE_EFF == 1) ? ST_CHECK : ST_SETTLE;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    sr_cmd_t                  cmd_p0;
    sr_cmd_t                  cmd_p1;
    logic                     cmd_change;
    logic                     cmd_invalid;
    logic                     cmd_drive;

    chk_state_t               cur_st;
    chk_state_t               nxt_st;
    logic [SETTLE_CNT_W-1:0]  settle_cnt;
    logic [SETTLE_CNT_W-1:0]  settle_nxt;

    logic                     cmp_fire;
    logic                     cmp_pass;

    assign cmd_p0      = '{en: EN, s: S, r: R};
    assign cmd_change  = (cmd_p0 != cmd_p1);
    assign cmd_invalid = is_invalid(cmd_p0);
    assign cmd_drive   = is_drive(cmd_p0);

    // A compare passes only if both rails agree with the model.
    assign cmp_pass    = (Q == exp_q) && (Qbar != exp_q);

    assign state       = cur_st;

    sr_ref_model u_ref_model (
        .clk       (clk),
        .rst       (rst),
        .EN        (EN),
        .S         (S),
        .R         (R),
        .exp_q     (exp_q),
        .exp_known (exp_known)
    );

    // Stage p0: next-state decode from the sampled command
    always_comb begin
        nxt_st     = cur_st;
        settle_nxt = settle_cnt;
        cmp_fire   = 1'b0;

        if (cmd_invalid) begin
            // The forbidden command overrides every state.
            nxt_st     = ST_INVALID;
            settle_nxt = '0;
        end else begin
            case (cur_st)
                ST_UNKNOWN: begin
                    // Only an enabled set/reset makes the model defined;
                    // EN=0 or a hold leaves it unknown.
                    if (cmd_drive) begin
                        nxt_st     = SETTLE_ENTRY;
                        settle_nxt = SETTLE_LOAD;
                    end
                end
                ST_SETTLE: begin
                    if (cmd_change) begin
                        nxt_st     = SETTLE_ENTRY;
                        settle_nxt = SETTLE_LOAD;
                    end else if (settle_cnt <= SETTLE_CNT_W'(1)) begin
                        nxt_st     = ST_CHECK;
                        settle_nxt = '0;
                    end else begin
                        settle_nxt = settle_cnt - SETTLE_CNT_W'(1);
                    end
                end
                ST_CHECK: begin
                    // A command change wins over the compare on this sample.
                    if (cmd_change) begin
                        nxt_st     = SETTLE_ENTRY;
                        settle_nxt = SETTLE_LOAD;
                    end else begin
                        cmp_fire   = 1'b1;
                    end
                end
                ST_INVALID: begin
                    if (cmd_drive) begin
                        nxt_st     = SETTLE_ENTRY;
                        settle_nxt = SETTLE_LOAD;
                    end else begin
                        nxt_st     = ST_UNKNOWN;
                        settle_nxt = '0;
                    end
                end
                default: begin
                    nxt_st     = ST_UNKNOWN;
                    settle_nxt = '0;
                end
            endcase
        end
    end

    // Stage p0 -> p1: FSM, settle counter and previous-command register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_st     <= ST_UNKNOWN;
            settle_cnt <= '0;
            cmd_p1     <= '0;
        end else begin
            cur_st     <= nxt_st;
            settle_cnt <= settle_nxt;
            cmd_p1     <= cmd_p0;
        end
    end

    // Stage p0 -> p1: compare result, counters and sticky flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mismatch     <= 1'b0;
            invalid_seen <= 1'b0;
            err_count    <= '0;
            chk_count    <= '0;
        end else begin
            // The pulse is independent of clear so a failure is never hidden.
            mismatch <= cmp_fire & ~cmp_pass;
            if (clear) begin
                invalid_seen <= 1'b0;
                err_count    <= '0;
                chk_count    <= '0;
            end else begin
                if (cmd_invalid) begin
                    invalid_seen <= 1'b1;
                end
                if (cmp_fire) begin
                    chk_count <= sat_inc(chk_count);
                end
                if (cmp_fire && !cmp_pass) begin
                    err_count <= sat_inc(err_count);
                end
            end
        end
    end

endmodule

// File: tb/tb_sr_latch_checker.sv
// -----------------------------------------------------------------------------
// tb_sr_latch_checker
//
// Scoreboard bench for sr_latch_checker. Each stimulus step updates a
// behavioural model of the checker (latch value, cycles since the last command
// change, counters) and queues the outputs expected after the next clock edge;
// an independent monitor pops one expectation per clock edge and compares.
// -----------------------------------------------------------------------------
module tb_sr_latch_checker;

    localparam int SETTLE  = 2;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             EN, S, R, Q, Qbar, clear;
    logic             exp_q, exp_known, mismatch, invalid_seen;
    logic [CNT_W-1:0] err_count, chk_count;
    logic [1:0]       state;

    sr_latch_checker #(.SETTLE(SETTLE), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .EN           (EN),
        .S            (S),
        .R            (R),
        .Q            (Q),
        .Qbar         (Qbar),
        .clear        (clear),
        .exp_q        (exp_q),
        .exp_known    (exp_known),
        .mismatch     (mismatch),
        .invalid_seen (invalid_seen),
        .err_count    (err_count),
        .chk_count    (chk_count),
        .state        (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st;
        bit known;
        bit q;
        bit mm;
        bit inv;
        int err;
        int chk;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;

    // Behavioural model state
    logic [2:0] m_prev;
    bit         m_known, m_q, m_inv;
    int         m_age, m_err, m_chk;

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, got, want);
        end
    endtask

    task automatic model_reset();
        m_prev  = 3'b000;
        m_known = 1'b0;
        m_q     = 1'b0;
        m_inv   = 1'b0;
        m_age   = 0;
        m_err   = 0;
        m_chk   = 0;
    endtask

    // Called at a falling edge: drives one command and queues the outputs
    // expected after the following rising edge, then waits one cycle.
    task automatic step(input logic en, input logic s, input logic r,
                        input logic q, input logic qb, input logic clr);
        exp_t       e;
        logic [2:0] cmd;
        bit         chg, inv, cmp, fail;
        int         age_new;
        cmd     = {en, s, r};
        chg     = (cmd != m_prev);
        inv     = en & s & r;
        age_new = chg ? 0 : ((m_age < 1000) ? m_age + 1 : m_age);
        // First compare lands SETTLE cycles after the last command change.
        cmp     = m_known && !chg && !inv && (age_new >= SETTLE);
        fail    = cmp && ((q != m_q) || (qb != !m_q));

        EN = en; S = s; R = r; Q = q; Qbar = qb; clear = clr;

        if (en) begin
            if (inv)    m_known = 1'b0;
            else if (s) begin m_q = 1'b1; m_known = 1'b1; end
            else if (r) begin m_q = 1'b0; m_known = 1'b1; end
        end
        m_age  = age_new;
        m_prev = cmd;

        if (clr) begin
            m_err = 0; m_chk = 0; m_inv = 1'b0;
        end else begin
            if (cmp && m_chk < CNT_MAX)  m_chk++;
            if (fail && m_err < CNT_MAX) m_err++;
            if (inv) m_inv = 1'b1;
        end

        e.st    = inv ? 3 : (m_known ? ((m_age >= SETTLE - 1) ? 2 : 1) : 0);
        e.known = m_known;
        e.q     = m_q;
        e.mm    = fail;
        e.inv   = m_inv;
        e.err   = m_err;
        e.chk   = m_chk;
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic good(input logic en, input logic s, input logic r, input logic clr);
        step(en, s, r, m_q, !m_q, clr);
    endtask

    task automatic bad(input logic en, input logic s, input logic r, input logic clr);
        step(en, s, r, !m_q, m_q, clr);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"},     int'(state),        0);
        check({tag, "_exp_q"},     int'(exp_q),        0);
        check({tag, "_exp_known"}, int'(exp_known),    0);
        check({tag, "_mismatch"},  int'(mismatch),     0);
        check({tag, "_inv_seen"},  int'(invalid_seen), 0);
        check({tag, "_err_count"}, int'(err_count),    0);
        check({tag, "_chk_count"}, int'(chk_count),    0);
    endtask

    // Asynchronous reset between clock edges, then release at a falling edge.
    task automatic do_async_reset(input string tag);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_reset_values(tag);
        @(negedge clk);
        rst = 1'b0;
        EN = 1'b0; S = 1'b0; R = 1'b0; Q = 1'b0; Qbar = 1'b1; clear = 1'b0;
        model_reset();
    endtask

    // Monitor: one expectation per rising edge, sampled 1 time unit later.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check("state",        int'(state),        e.st);
            check("exp_known",    int'(exp_known),    int'(e.known));
            if (e.known) check("exp_q", int'(exp_q),  int'(e.q));
            check("mismatch",     int'(mismatch),     int'(e.mm));
            check("invalid_seen", int'(invalid_seen), int'(e.inv));
            check("err_count",    int'(err_count),    e.err);
            check("chk_count",    int'(chk_count),    e.chk);
        end
    end

    initial begin
        logic [2:0] c;
        bit         q_ok;
        bit         clr;
        int         budget;

        rst = 1'b1;
        EN = 1'b0; S = 1'b0; R = 1'b0; Q = 1'b0; Qbar = 1'b1; clear = 1'b0;
        model_reset();
        @(negedge clk);
        check_reset_values("rst");
        rst = 1'b0;

        // Set with a correct latch, then hold / reset / hold
        repeat (5) good(1, 1, 0, 0);
        repeat (4) good(1, 0, 0, 0);
        repeat (4) good(1, 0, 1, 0);
        repeat (4) good(1, 0, 0, 0);

        // Single failing compare, then saturation of err_count
        bad(1, 0, 0, 0);
        repeat (3) good(1, 0, 0, 0);
        repeat (3) good(1, 1, 0, 0);
        repeat (300) bad(1, 1, 0, 0);
        good(1, 1, 0, 1);
        repeat (2) good(1, 1, 0, 0);

        // Invalid command, disabled command while unknown, then recovery
        repeat (3) good(1, 1, 1, 0);
        repeat (3) good(0, 1, 0, 0);
        repeat (4) good(1, 1, 0, 0);

        // Command change on a compare cycle with a wrong Q
        bad(1, 0, 0, 0);
        repeat (3) good(1, 0, 0, 0);

        // Clear together with a failing compare
        bad(1, 0, 0, 1);
        repeat (2) good(1, 0, 0, 0);

        // Reset mid-CHECK, then confirm normal operation resumes
        repeat (4) good(1, 1, 0, 0);
        do_async_reset("arst1");
        repeat (4) good(1, 0, 1, 0);

        // Randomised traffic with occasional faults, clears and a reset
        c = 3'b100;
        for (int i = 0; i < 2000; i++) begin
            if (i == 1000) begin
                do_async_reset("arst2");
                c = 3'b000;
            end
            if ($urandom_range(0, 9) < 3) c = 3'($urandom_range(0, 7));
            q_ok = ($urandom_range(0, 9) < 8);
            clr  = ($urandom_range(0, 49) == 0);
            if (q_ok) step(c[2], c[1], c[0], m_q, !m_q, clr);
            else      step(c[2], c[1], c[0], 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)), clr);
        end

        budget = 0;
        while (sb_q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        #2;
        check("scoreboard_drain", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
